// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the lighthouse pulse-identification path.
// Used by the offset finder and the polynomial manager.
package lfsr_pkg;

    localparam int LFSR_W = 17;
    localparam logic [LFSR_W-1:0] SEED = 17'h00001;
    localparam logic [LFSR_W-1:0] MAX_STEPS = 17'd131071;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Fibonacci step: feedback shifts in at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] poly
    );
        return {s[LFSR_W-2:0], ^(s & poly)};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational Fibonacci LFSR step.
// Chained twice by the finder in dual-step builds.
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] state,
    input  logic [LFSR_W-1:0] poly,
    output logic [LFSR_W-1:0] next_state
);

    assign next_state = lfsr_next(state, poly);

endmodule

// File: rtl/lfsr_offset_finder.sv
// Locates a 17-bit LFSR word in the sequence from SEED; offset 0 = not found.
// Define LFSR_OFFSET_FINDER_DUAL_STEP_EN to search two steps per cycle.
module lfsr_offset_finder
    import lfsr_pkg::*;
(
    input  logic              clk_72MHz,
    input  logic              reset,
    input  logic [LFSR_W-1:0] polynomial,
    input  logic [LFSR_W-1:0] data,
    input  logic              enable,
    output logic [LFSR_W-1:0] offset,
    output logic              ready
);

    state_t            state;
    logic [LFSR_W-1:0] s;
    logic [LFSR_W-1:0] count;
    logic [LFSR_W-1:0] poly_q;
    logic [LFSR_W-1:0] data_q;

    logic [LFSR_W-1:0] s1;
    logic [LFSR_W-1:0] count1;
    logic              hit1;

    lfsr_step u_step1 (
        .state      (s),
        .poly       (poly_q),
        .next_state (s1)
    );

    // SEED can only recur at the very last step, where it reads as not found.
    assign count1 = count + 17'd1;
    assign hit1   = (s1 == data_q) && (data_q != SEED);

`ifdef LFSR_OFFSET_FINDER_DUAL_STEP_EN
    logic [LFSR_W-1:0] s2;
    logic [LFSR_W-1:0] count2;
    logic              hit2;

    lfsr_step u_step2 (
        .state      (s1),
        .poly       (poly_q),
        .next_state (s2)
    );

    assign count2 = count + 17'd2;
    assign hit2   = (s2 == data_q) && (data_q != SEED);
`endif

    assign ready = (state == DONE);

    always_ff @(posedge clk_72MHz) begin
        if (reset) begin
            state  <= IDLE;
            s      <= SEED;
            count  <= '0;
            offset <= '0;
            poly_q <= '0;
            data_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        poly_q <= polynomial;
                        data_q <= data;
                        s      <= SEED;
                        count  <= '0;
                        if (polynomial == '0 || data == '0) begin
                            offset <= '0;
                            state  <= DONE;
                        end else begin
                            state  <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else begin
`ifdef LFSR_OFFSET_FINDER_DUAL_STEP_EN
                        if (hit1 || count1 == MAX_STEPS) begin
                            s      <= s1;
                            count  <= count1;
                            offset <= hit1 ? count1 : '0;
                            state  <= DONE;
                        end else begin
                            s     <= s2;
                            count <= count2;
                            if (hit2 || count2 == MAX_STEPS) begin
                                offset <= hit2 ? count2 : '0;
                                state  <= DONE;
                            end
                        end
`else
                        s     <= s1;
                        count <= count1;
                        if (hit1 || count1 == MAX_STEPS) begin
                            offset <= hit1 ? count1 : '0;
                            state  <= DONE;
                        end
`endif
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_offset_finder.sv
// Scoreboard bench for lfsr_offset_finder with a plain-loop sequence model.
// Honours LFSR_OFFSET_FINDER_DUAL_STEP_EN for expected latencies.
module tb_lfsr_offset_finder;

    logic        clk_72MHz = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] polynomial = '0;
    logic [16:0] data = '0;
    logic        enable = 1'b0;
    logic [16:0] offset;
    logic        ready;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [16:0] off;
        int          edge_no;
    } exp_t;

    exp_t exp_q[$];

    lfsr_offset_finder dut (
        .clk_72MHz  (clk_72MHz),
        .reset      (reset),
        .polynomial (polynomial),
        .data       (data),
        .enable     (enable),
        .offset     (offset),
        .ready      (ready)
    );

    always #5 clk_72MHz = ~clk_72MHz;

    always @(posedge clk_72MHz) cyc <= cyc + 1;

    // Position of d in the sequence from 1: 0 = rejected, -1 = not found.
    function automatic int ref_steps(input logic [16:0] p, input logic [16:0] d);
        logic [16:0] v;
        if (p == 0 || d == 0) return 0;
        if (d == 17'h1) return -1;
        v = 17'h1;
        for (int n = 1; n <= 131071; n++) begin
            v = {v[15:0], ^(v & p)};
            if (v == d) return n;
        end
        return -1;
    endfunction

    function automatic int edges_for(input int n);
`ifdef LFSR_OFFSET_FINDER_DUAL_STEP_EN
        if (n < 0) return 65536;
        return (n + 1) / 2;
`else
        if (n < 0) return 131071;
        return n;
`endif
    endfunction

    // Monitor: pops on each rising ready, checks offset stays put while high.
    logic        ready_d = 1'b0;
    logic [16:0] held = '0;
    always @(negedge clk_72MHz) begin
        exp_t e;
        if (!reset && ready && !ready_d) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result offset=%0d expected none", offset);
            end else begin
                e = exp_q.pop_front();
                if (offset !== e.off || cyc != e.edge_no) begin
                    bad++;
                    $display("FAIL result offset=%0d edge=%0d expected offset=%0d edge=%0d",
                             offset, cyc, e.off, e.edge_no);
                end
            end
            held = offset;
        end else if (!reset && ready && ready_d) begin
            total++;
            if (offset !== held) begin
                bad++;
                $display("FAIL offset_stable got=%0d expected=%0d", offset, held);
            end
        end
        ready_d = ready;
    end

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Full transaction: enable, wait for ready, hold, release, check ready falls.
    task automatic run(input logic [16:0] p, input logic [16:0] d, input int hold);
        int n;
        int k;
        int waited;
        exp_t e;
        n = ref_steps(p, d);
        k = (p == 0 || d == 0) ? 0 : edges_for(n);
        @(negedge clk_72MHz);
        polynomial = p;
        data = d;
        enable = 1'b1;
        e.off = (n > 0) ? n[16:0] : 17'd0;
        e.edge_no = cyc + 1 + k;
        exp_q.push_back(e);
        waited = 0;
        @(negedge clk_72MHz);
        while (!ready && waited < k + 8) begin
            polynomial = 17'($urandom);
            data = 17'($urandom);
            @(negedge clk_72MHz);
            waited++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout p=%0h d=%0h waited=%0d", p, d, waited);
            void'(exp_q.pop_front());
        end
        repeat (hold) begin
            polynomial = 17'($urandom);
            data = 17'($urandom);
            @(negedge clk_72MHz);
        end
        enable = 1'b0;
        @(negedge clk_72MHz);
        check("ready_falls", {16'd0, ready}, 17'd0);
    endtask

    initial begin
        #(20_000_000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] p;
        logic [16:0] d;
        logic [16:0] v;
        logic [16:0] last;
        int m;
        int n;

        repeat (3) @(negedge clk_72MHz);
        check("reset_ready", {16'd0, ready}, 17'd0);
        check("reset_offset", offset, 17'd0);
        reset = 1'b0;
        @(negedge clk_72MHz);

        run(17'h00003, 17'h00003, 0);
        run(17'h00003, 17'h00006, 3);
        run(17'h00000, 17'h00005, 0);
        run(17'h00005, 17'h00000, 1);

        // Abort with enable low: offset keeps last result, no ready.
        last = offset;
        @(negedge clk_72MHz);
        polynomial = 17'h00001;
        data = 17'h00002;
        enable = 1'b1;
        repeat (6) @(negedge clk_72MHz);
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk_72MHz);
            check("abort_ready", {16'd0, ready}, 17'd0);
            check("abort_offset", offset, last);
        end

        run(17'h00003, 17'h00006, 0);

        // Reset at step 10 of an unreachable search.
        @(negedge clk_72MHz);
        polynomial = 17'h00001;
        data = 17'h00002;
        enable = 1'b1;
        repeat (11) @(negedge clk_72MHz);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk_72MHz);
        check("mid_reset_ready", {16'd0, ready}, 17'd0);
        check("mid_reset_offset", offset, 17'd0);
        reset = 1'b0;
        @(negedge clk_72MHz);
        run(17'h00003, 17'h00003, 2);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                p = ($urandom_range(0, 1) == 0) ? 17'd0 : 17'($urandom);
                d = (p == 0) ? 17'($urandom) : 17'd0;
            end else begin
                n = -1;
                while (n < 1) begin
                    p = 17'($urandom);
                    m = $urandom_range(1, 300);
                    v = 17'h1;
                    for (int i = 0; i < m; i++) v = {v[15:0], ^(v & p)};
                    d = v;
                    n = (p == 0) ? -1 : ref_steps(p, d);
                end
            end
            run(p, d, $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk_72MHz);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
